// File: rtl/obj_line_scanner.sv
// obj_line_scanner
// Walks the object RAM once per scanline and emits a descriptor for every
// entry whose vertical extent covers the requested line.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; obj_addr_o holds its last value
// FETCH | obj_addr_o = idx, RAM read in flight
// EVAL  | obj_q64_i holds entry idx; test end-of-list and extent
// EMIT  | descriptor presented, waiting for out_ready_i
// DONE  | one-cycle done_o pulse
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i, line_i         scan request and target line
//   obj_addr_o, obj_q64_i   RAM wide read port (1-cycle latency)
//   out_valid_o/out_ready_i descriptor handshake, out_* descriptor fields
//   busy_o, done_o          scan in progress / scan finished pulse
//   overflow_o              last scan stopped at MAX_HITS
module obj_line_scanner #(
   parameter int NUM_OBJ  = 512,
   parameter int MAX_HITS = 32
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [8:0]  line_i,
   output logic [8:0]  obj_addr_o,
   input  logic [63:0] obj_q64_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [15:0] out_code_o,
   output logic [9:0]  out_x_o,
   output logic [6:0]  out_row_o,
   output logic [1:0]  out_wsel_o,
   output logic [6:0]  out_color_o,
   output logic        out_prio_o,
   output logic        out_flipx_o,
   output logic [8:0]  out_index_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        overflow_o
);

   typedef enum logic [2:0] {IDLE, FETCH, EVAL, EMIT, DONE} state_t;

   typedef struct packed {
      logic [15:0] code;
      logic [9:0]  x;
      logic [6:0]  row;
      logic [1:0]  wsel;
      logic [6:0]  color;
      logic        prio;
      logic        flipx;
      logic [8:0]  index;
   } desc_t;

   state_t      state_q, state_d;
   logic [8:0]  line_q, line_d;
   logic [9:0]  idx_q, idx_d;
   logic [9:0]  hits_q, hits_d;
   logic [8:0]  addr_q, addr_d;
   logic        ovf_q, ovf_d;
   logic        valid_q, valid_d;
   desc_t       desc_q, desc_d;

   logic [8:0]  ent_y;
   logic [1:0]  ent_hsel;
   logic        ent_eol;
   logic        ent_flipy;
   logic [8:0]  ent_h;
   logic [8:0]  ent_r;
   logic [8:0]  ent_row;
   logic        ent_hit;
   logic [9:0]  idx_inc;
   logic [9:0]  hits_inc;
   logic        unused_bits;

   assign ent_y     = obj_q64_i[8:0];
   assign ent_hsel  = obj_q64_i[10:9];
   assign ent_eol   = obj_q64_i[15];
   assign ent_flipy = obj_q64_i[41];
   assign ent_h     = 9'd16 << ent_hsel;
   // Modulo-512 subtraction handles objects wrapping past the bottom line.
   assign ent_r     = line_q - ent_y;
   assign ent_hit   = ent_r < ent_h;
   assign ent_row   = ent_flipy ? (ent_h - 9'd1 - ent_r) : ent_r;
   assign idx_inc   = idx_q + 10'd1;
   assign hits_inc  = hits_q + 10'd1;

   assign unused_bits = ^{obj_q64_i[14:13], obj_q64_i[47:42], obj_q64_i[63:58]};

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      idx_d   = idx_q;
      hits_d  = hits_q;
      addr_d  = addr_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      desc_d  = desc_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               line_d  = line_i;
               idx_d   = '0;
               hits_d  = '0;
               ovf_d   = 1'b0;
               addr_d  = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = EVAL;
         EVAL: begin
            if (ent_eol) begin
               state_d = DONE;
            end else if (ent_hit) begin
               desc_d.code  = obj_q64_i[31:16];
               desc_d.x     = obj_q64_i[57:48];
               desc_d.row   = ent_row[6:0];
               desc_d.wsel  = obj_q64_i[12:11];
               desc_d.color = obj_q64_i[38:32];
               desc_d.prio  = obj_q64_i[39];
               desc_d.flipx = obj_q64_i[40];
               desc_d.index = idx_q[8:0];
               valid_d      = 1'b1;
               state_d      = EMIT;
            end else begin
               idx_d = idx_inc;
               if (idx_inc == 10'(NUM_OBJ)) begin
                  state_d = DONE;
               end else begin
                  addr_d  = idx_inc[8:0];
                  state_d = FETCH;
               end
            end
         end
         EMIT: begin
            if (out_ready_i) begin
               valid_d = 1'b0;
               hits_d  = hits_inc;
               idx_d   = idx_inc;
               // Hit limit takes precedence so a full final entry still flags overflow.
               if (hits_inc == 10'(MAX_HITS)) begin
                  ovf_d   = 1'b1;
                  state_d = DONE;
               end else if (idx_inc == 10'(NUM_OBJ)) begin
                  state_d = DONE;
               end else begin
                  addr_d  = idx_inc[8:0];
                  state_d = FETCH;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         line_q  <= '0;
         idx_q   <= '0;
         hits_q  <= '0;
         addr_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         desc_q  <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         idx_q   <= idx_d;
         hits_q  <= hits_d;
         addr_q  <= addr_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         desc_q  <= desc_d;
      end
   end

   assign obj_addr_o  = addr_q;
   assign out_valid_o = valid_q;
   assign out_code_o  = desc_q.code;
   assign out_x_o     = desc_q.x;
   assign out_row_o   = desc_q.row;
   assign out_wsel_o  = desc_q.wsel;
   assign out_color_o = desc_q.color;
   assign out_prio_o  = desc_q.prio;
   assign out_flipx_o = desc_q.flipx;
   assign out_index_o = desc_q.index;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_obj_line_scanner.sv
module tb_obj_line_scanner;

   logic        clk = 1'b0;
   logic        reset, start, ready;
   logic [8:0]  line;
   logic [63:0] mem [0:511];
   logic [63:0] q_a, q_b;

   logic [8:0]  addr_a, addr_b, idx_a, idx_b;
   logic        val_a, val_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
   logic [15:0] code_a, code_b;
   logic [9:0]  x_a, x_b;
   logic [6:0]  row_a, row_b, col_a, col_b;
   logic [1:0]  wsel_a, wsel_b;
   logic        prio_a, prio_b, flipx_a, flipx_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
   end

   obj_line_scanner #(.NUM_OBJ(4), .MAX_HITS(32)) dut_a (
      .clk_i(clk), .reset_i(reset), .start_i(start), .line_i(line),
      .obj_addr_o(addr_a), .obj_q64_i(q_a), .out_valid_o(val_a), .out_ready_i(ready),
      .out_code_o(code_a), .out_x_o(x_a), .out_row_o(row_a), .out_wsel_o(wsel_a),
      .out_color_o(col_a), .out_prio_o(prio_a), .out_flipx_o(flipx_a), .out_index_o(idx_a),
      .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a));

   obj_line_scanner #(.NUM_OBJ(4), .MAX_HITS(2)) dut_b (
      .clk_i(clk), .reset_i(reset), .start_i(start), .line_i(line),
      .obj_addr_o(addr_b), .obj_q64_i(q_b), .out_valid_o(val_b), .out_ready_i(ready),
      .out_code_o(code_b), .out_x_o(x_b), .out_row_o(row_b), .out_wsel_o(wsel_b),
      .out_color_o(col_b), .out_prio_o(prio_b), .out_flipx_o(flipx_b), .out_index_o(idx_b),
      .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b));

   typedef struct {
      int         idx;
      logic [6:0] row;
      logic [15:0] code;
      logic [9:0] x;
      logic [6:0] color;
      logic [1:0] wsel;
      logic       prio;
      logic       flipx;
   } desc_t;

   desc_t qa[$];
   desc_t qb[$];
   int    da, db;

   typedef struct {
      logic [8:0] y;
      logic [1:0] hsel;
      logic       flipy;
      logic [8:0] ln;
      int         exp_hit;
      logic [6:0] exp_row;
   } vec_t;

   vec_t vt[10];

   function automatic logic [63:0] ent(input logic [8:0] y, input logic [1:0] hsel,
                                       input logic [1:0] wsel, input logic eol,
                                       input logic [15:0] code, input logic [6:0] color,
                                       input logic prio, input logic flipx, input logic flipy,
                                       input logic [9:0] x);
      logic [15:0] w0, w2, w3;
      w0 = {eol, 2'b00, wsel, hsel, y};
      w2 = {6'b0, flipy, flipx, prio, color};
      w3 = {6'b0, x};
      return {w3, w2, code, w0};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] miss_ent();
      return ent(9'd300, 2'd0, 2'd0, 1'b0, 16'h0, 7'd0, 1'b0, 1'b0, 1'b0, 10'd0);
   endfunction

   function automatic logic [63:0] hit_ent(input logic [15:0] code);
      // y=0, h=16: covers lines 0..15
      return ent(9'd0, 2'd0, 2'd1, 1'b0, code, 7'd3, 1'b0, 1'b1, 1'b0, 10'd7);
   endfunction

   task automatic fill_miss();
      for (int i = 0; i < 8; i++) mem[i] = miss_ent();
   endtask

   // Returns at the negedge of cycle 1 (state FETCH idx0).
   task automatic start_scan(input logic [8:0] l);
      @(negedge clk);
      line  = l;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic capture(input int c0, input int maxc);
      desc_t d;
      da = 0;
      db = 0;
      qa.delete();
      qb.delete();
      for (int c = c0; c <= maxc; c++) begin
         if (val_a && ready) begin
            d.idx = int'(idx_a); d.row = row_a; d.code = code_a; d.x = x_a;
            d.color = col_a; d.wsel = wsel_a; d.prio = prio_a; d.flipx = flipx_a;
            qa.push_back(d);
         end
         if (val_b && ready) begin
            d.idx = int'(idx_b); d.row = row_b; d.code = code_b; d.x = x_b;
            d.color = col_b; d.wsel = wsel_b; d.prio = prio_b; d.flipx = flipx_b;
            qb.push_back(d);
         end
         if (done_a && da == 0) da = c;
         if (done_b && db == 0) db = c;
         if (da != 0 && db != 0) break;
         @(negedge clk);
      end
      chk("scan_finished", 32'(da != 0 && db != 0), 32'd1);
   endtask

   initial begin
      int busy_err, val_seen, done_cnt, done_cyc, stable_err, waited;
      logic [63:0] snap;

      vt[0] = '{9'd8,   2'd1, 1'b0, 9'd20,  1, 7'd12};
      vt[1] = '{9'd8,   2'd1, 1'b1, 9'd20,  1, 7'd19};
      vt[2] = '{9'd500, 2'd0, 1'b0, 9'd3,   1, 7'd15};
      vt[3] = '{9'd500, 2'd0, 1'b0, 9'd4,   0, 7'd0};
      vt[4] = '{9'd0,   2'd3, 1'b0, 9'd127, 1, 7'd127};
      vt[5] = '{9'd0,   2'd3, 1'b0, 9'd128, 0, 7'd0};
      vt[6] = '{9'd0,   2'd3, 1'b1, 9'd0,   1, 7'd127};
      vt[7] = '{9'd10,  2'd2, 1'b1, 9'd73,  1, 7'd0};
      vt[8] = '{9'd10,  2'd2, 1'b0, 9'd9,   0, 7'd0};
      vt[9] = '{9'd100, 2'd0, 1'b1, 9'd100, 1, 7'd15};

      for (int i = 0; i < 512; i++) mem[i] = '0;
      reset = 1'b1; start = 1'b0; ready = 1'b1; line = '0;
      repeat (2) @(negedge clk);
      chk("rst_addr", 32'(addr_a), 32'd0);
      chk("rst_valid", 32'(val_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_ovf", 32'(ovf_a), 32'd0);
      chk("rst_code", 32'(code_a), 32'd0);
      reset = 1'b0;

      // All-miss scan: done only in cycle 9, busy in cycles 1..9
      fill_miss();
      start_scan(9'd10);
      busy_err = 0; val_seen = 0; done_cnt = 0; done_cyc = 0;
      for (int c = 1; c <= 12; c++) begin
         if (busy_a !== (c <= 9)) busy_err++;
         if (val_a) val_seen++;
         if (done_a) begin done_cnt++; done_cyc = c; end
         @(negedge clk);
      end
      chk("miss_busy_window", 32'(busy_err), 32'd0);
      chk("miss_valid_seen", 32'(val_seen), 32'd0);
      chk("miss_done_count", 32'(done_cnt), 32'd1);
      chk("miss_done_cycle", 32'(done_cyc), 32'd9);

      // Single-entry extent table: entry at idx0, end-of-list at idx1
      for (int v = 0; v < 10; v++) begin
         fill_miss();
         mem[0] = ent(vt[v].y, vt[v].hsel, 2'd0, 1'b0, 16'hBEEF, 7'd1, 1'b0, 1'b0,
                      vt[v].flipy, 10'd1);
         mem[1] = ent(9'd0, 2'd0, 2'd0, 1'b1, 16'h0, 7'd0, 1'b0, 1'b0, 1'b0, 10'd0);
         start_scan(vt[v].ln);
         capture(1, 30);
         chk($sformatf("vec%0d_hits", v), 32'(qa.size()), 32'(vt[v].exp_hit));
         if (qa.size() > 0) chk($sformatf("vec%0d_row", v), 32'(qa[0].row), 32'(vt[v].exp_row));
      end

      // Single hit at idx2, flipy 0 and 1
      for (int f = 0; f < 2; f++) begin
         fill_miss();
         mem[2] = ent(9'd8, 2'd1, 2'd2, 1'b0, 16'h1234, 7'd5, 1'b1, 1'b0, f[0], 10'h155);
         start_scan(9'd20);
         capture(1, 30);
         chk("hit2_count", 32'(qa.size()), 32'd1);
         if (qa.size() > 0) begin
            chk("hit2_index", 32'(qa[0].idx), 32'd2);
            chk("hit2_row", 32'(qa[0].row), (f == 0) ? 32'd12 : 32'd19);
            chk("hit2_code", 32'(qa[0].code), 32'h1234);
            chk("hit2_x", 32'(qa[0].x), 32'h155);
            chk("hit2_color", 32'(qa[0].color), 32'd5);
            chk("hit2_wsel", 32'(qa[0].wsel), 32'd2);
            chk("hit2_prio", 32'(qa[0].prio), 32'd1);
         end
         chk("hit2_done_cycle", 32'(da), 32'd10);
      end

      // Backpressure: hit at idx1, ready low for 5 cycles
      fill_miss();
      mem[1] = ent(9'd0, 2'd0, 2'd3, 1'b0, 16'hA5A5, 7'd9, 1'b0, 1'b1, 1'b0, 10'd77);
      ready = 1'b0;
      start_scan(9'd5);
      waited = 0;
      while (!val_a && waited < 20) begin @(negedge clk); waited++; end
      chk("bp_valid_rise", 32'(val_a), 32'd1);
      snap = {code_a, x_a, row_a, wsel_a, col_a, prio_a, flipx_a, idx_a, 2'b0};
      stable_err = 0;
      for (int c = 0; c < 5; c++) begin
         if (!val_a) stable_err++;
         if ({code_a, x_a, row_a, wsel_a, col_a, prio_a, flipx_a, idx_a, 2'b0} !== snap)
            stable_err++;
         if (addr_a !== 9'd1) stable_err++;
         @(negedge clk);
      end
      chk("bp_stable", 32'(stable_err), 32'd0);
      chk("bp_index", 32'(idx_a), 32'd1);
      ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drop", 32'(val_a), 32'd0);
      chk("bp_resume_addr", 32'(addr_a), 32'd2);
      capture(1, 30);
      chk("bp_no_more_hits", 32'(qa.size()), 32'd0);

      // Overflow: all four entries hit; dut_b stops after two
      for (int i = 0; i < 4; i++) mem[i] = hit_ent(16'(i));
      start_scan(9'd5);
      capture(1, 40);
      chk("ovf_b_count", 32'(qb.size()), 32'd2);
      if (qb.size() == 2) begin
         chk("ovf_b_idx0", 32'(qb[0].idx), 32'd0);
         chk("ovf_b_idx1", 32'(qb[1].idx), 32'd1);
      end
      chk("ovf_b_done_cycle", 32'(db), 32'd7);
      @(negedge clk);
      chk("ovf_b_flag", 32'(ovf_b), 32'd1);
      chk("ovf_a_count", 32'(qa.size()), 32'd4);
      chk("ovf_a_flag", 32'(ovf_a), 32'd0);

      // A new start clears overflow
      fill_miss();
      start_scan(9'd5);
      chk("ovf_cleared", 32'(ovf_b), 32'd0);
      capture(1, 30);

      // Overflow reached on the final entry
      fill_miss();
      mem[2] = hit_ent(16'h2);
      mem[3] = hit_ent(16'h3);
      start_scan(9'd5);
      capture(1, 30);
      chk("ovf_last_count", 32'(qb.size()), 32'd2);
      if (qb.size() == 2) chk("ovf_last_idx", 32'(qb[1].idx), 32'd3);
      chk("ovf_last_done_cycle", 32'(db), 32'd11);
      @(negedge clk);
      chk("ovf_last_flag", 32'(ovf_b), 32'd1);

      // End-of-list at idx1; idx1 and idx2 would otherwise hit
      fill_miss();
      mem[0] = hit_ent(16'h10);
      mem[1] = ent(9'd0, 2'd0, 2'd0, 1'b1, 16'h11, 7'd0, 1'b0, 1'b0, 1'b0, 10'd0);
      mem[2] = hit_ent(16'h12);
      start_scan(9'd5);
      capture(1, 30);
      chk("eol_count", 32'(qa.size()), 32'd1);
      if (qa.size() > 0) chk("eol_idx", 32'(qa[0].idx), 32'd0);
      chk("eol_done_cycle", 32'(da), 32'd6);

      // End-of-list at idx0
      mem[0] = ent(9'd0, 2'd0, 2'd0, 1'b1, 16'h0, 7'd0, 1'b0, 1'b0, 1'b0, 10'd0);
      start_scan(9'd5);
      capture(1, 30);
      chk("eol0_done_cycle", 32'(da), 32'd3);

      // Reset while in EMIT
      fill_miss();
      mem[0] = hit_ent(16'h77);
      ready = 1'b0;
      start_scan(9'd5);
      waited = 0;
      while (!val_a && waited < 20) begin @(negedge clk); waited++; end
      chk("rst_emit_valid_rise", 32'(val_a), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_emit_valid", 32'(val_a), 32'd0);
      chk("rst_emit_busy", 32'(busy_a), 32'd0);
      done_cnt = 0;
      if (done_a) done_cnt++;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done_a) done_cnt++;
      end
      chk("rst_emit_no_done", 32'(done_cnt), 32'd0);
      ready = 1'b1;
      start_scan(9'd5);
      capture(1, 30);
      chk("rescan_count", 32'(qa.size()), 32'd1);
      if (qa.size() > 0) chk("rescan_idx", 32'(qa[0].idx), 32'd0);
      chk("rescan_done_cycle", 32'(da), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
